fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the pipelined CPU, sitting directly upstream of the
//   asynchronous-read instruction memory. Owns the program counter and drives the
//   memory word address. Captures the returned word into the IF/ID pipeline
//   register. Handles decode-stage stall, execute-stage branch/jump redirect, and
//   fetch faults.
// PARAMETERS
//   ADDR_BIT_WIDTH  11        instruction memory word-address width
//   DATA_BIT_WIDTH  32        instruction width
//   PC_WIDTH        32        program counter width (byte address)
//   RESET_PC        32'h40    PC value loaded on reset
//   NOP_INST        32'h0     value driven on if_inst when no valid instruction
// PORTS
//   clk             in   1               rising-edge clock
//   reset           in   1               asynchronous, active-high reset
//   stall           in   1               hold PC and IF/ID register
//   redirect_valid  in   1               load PC from redirect_pc; squash IF/ID
//   redirect_pc     in   PC_WIDTH        branch/jump target (byte address)
//   imem_addr       out  ADDR_BIT_WIDTH  word address to instruction memory
//   imem_data       in   DATA_BIT_WIDTH  combinational read data from memory
//   if_valid        out  1               IF/ID holds a real instruction
//   if_inst         out  DATA_BIT_WIDTH  fetched instruction
//   if_pc           out  PC_WIDTH        byte address of if_inst
//   if_pc_plus4     out  PC_WIDTH        if_pc + 4
//   fault           out  1               sticky fetch fault (misaligned/out of range)
// BEHAVIOUR
//   Reset (async, any time, including mid-stall or mid-redirect):
//   - pc=RESET_PC, state=BOOT, if_valid=0, if_inst=NOP_INST
//   - if_pc=0, if_pc_plus4=0, fault=0
//   imem_addr = pc[ADDR_BIT_WIDTH+1:2], combinational from the PC register.
//   Latency: the word at pc appears on if_inst/if_valid one clock later.
//   States:
//   - BOOT: one bubble cycle, if_valid=0, pc held -> RUN.
//     redirect_valid in BOOT is honoured (pc loads) -> RUN.
//   - RUN, priority redirect > stall > advance:
//     - redirect_valid: pc<=redirect_pc; if_valid<=0; if_inst<=NOP_INST.
//       Applies even while stall=1.
//     - stall (no redirect): pc and all if_* registers hold.
//     - advance: if_inst<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4,
//       if_valid<=1, pc<=pc+4.
//   - HALT: fault=1, if_valid=0, pc held; stall/redirect ignored.
//     Exits only by reset.
//   Faults (checked in RUN):
//   - redirect with redirect_pc[1:0]!=0 -> HALT next cycle, pc not loaded.
//   - advance with pc >= (1<<ADDR_BIT_WIDTH)*4 -> HALT, no instruction captured.
//   pc+4 arithmetic is modulo 2^PC_WIDTH; wrap is caught by the range check.
//   A stall asserted on the cycle a redirect clears IF/ID keeps if_valid=0.
// TESTING
//   1. Release reset with imem[16]=0xAAAA0001 -> cycle 1 if_valid=0, imem_addr=16;
//      cycle 2 if_inst=0xAAAA0001, if_pc=0x40, if_pc_plus4=0x44.
//   2. Run 4 cycles with no stall -> if_pc sequence 0x40,0x44,0x48,0x4C;
//      imem_addr steps by 1 each cycle.
//   3. stall=1 for 3 cycles at if_pc=0x44 -> if_* and imem_addr frozen;
//      release -> if_pc=0x48 next cycle.
//   4. redirect_valid=1 with stall=1 and redirect_pc=0x100 -> next cycle
//      if_valid=0, imem_addr=64; then stall=0 -> if_pc=0x100.
//   5. redirect_pc=0x102 -> fault=1 next cycle, if_valid stays 0;
//      later redirects ignored until reset clears fault.
//   6. Redirect to 0x1FFC, advance twice -> if_pc=0x1FFC captured,
//      then pc=0x2000 -> fault=1, if_valid=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the async-read imem word
// address and captures the returned word into the IF/ID pipeline register.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   stall                 hold PC and IF/ID register
//   redirect_valid/_pc    branch/jump target load, squashes IF/ID
//   imem_addr/imem_data   word address out, combinational read data in
//   if_valid/if_inst      IF/ID valid flag and instruction
//   if_pc/if_pc_plus4     byte address of if_inst and that address + 4
//   fault                 sticky fetch fault (misaligned or out of range)
module fetch_stage #(
    parameter int                 ADDR_BIT_WIDTH = 11,
    parameter int                 DATA_BIT_WIDTH = 32,
    parameter int                 PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = 32'h40,
    parameter logic [DATA_BIT_WIDTH-1:0] NOP_INST = 32'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    output logic [ADDR_BIT_WIDTH-1:0] imem_addr,
    input  logic [DATA_BIT_WIDTH-1:0] imem_data,
    output logic                      if_valid,
    output logic [DATA_BIT_WIDTH-1:0] if_inst,
    output logic [PC_WIDTH-1:0]       if_pc,
    output logic [PC_WIDTH-1:0]       if_pc_plus4,
    output logic                      fault
);

    // First byte address past the end of instruction memory.
    localparam logic [PC_WIDTH-1:0] PC_LIMIT =
        PC_WIDTH'(64'(1) << (ADDR_BIT_WIDTH + 2));

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic                      valid_q, valid_d;
    logic [DATA_BIT_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0]       ifpc_q, ifpc_d;
    logic [PC_WIDTH-1:0]       ifpc4_q, ifpc4_d;

    logic                      redir_bad;
    logic                      pc_oob;
    logic [PC_WIDTH-1:0]       pc_plus4;

    assign redir_bad = (redirect_pc[1:0] != 2'b00);
    // A wrapped pc+4 lands below the limit only after passing through it,
    // so the range check on the current pc is sufficient.
    assign pc_oob    = (pc_q >= PC_LIMIT);
    assign pc_plus4  = pc_q + PC_WIDTH'(4);

    // State and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid) begin
                    if (redir_bad) state_d = S_HALT;
                end else if (!stall && pc_oob) begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // PC and IF/ID register updates: redirect > stall > advance.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        case (state_q)
            S_BOOT: begin
                valid_d = 1'b0;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    if (!redir_bad) pc_d = redirect_pc;
                end else if (!stall) begin
                    if (pc_oob) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end else begin
                        valid_d = 1'b1;
                        inst_d  = imem_data;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_plus4;
                        pc_d    = pc_plus4;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        imem_addr   = pc_q[ADDR_BIT_WIDTH+1:2];
        if_valid    = valid_q;
        if_inst     = inst_q;
        if_pc       = ifpc_q;
        if_pc_plus4 = ifpc4_q;
        fault       = (state_q == S_HALT);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stall/redirect/reset traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fault;

    logic [31:0] mem [2048];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .fault          (fault)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: 0 = boot bubble, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h40;
        m_valid = 1'b0;
        m_inst  = 32'h0;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
    endtask

    task automatic model_step();
        if (m_mode == 0) begin
            if (redirect_valid) m_pc = redirect_pc;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_inst  = 32'h0;
                if (redirect_pc % 4 != 0) m_mode = 2;
                else m_pc = redirect_pc;
            end else if (!stall) begin
                if (m_pc >= 32'd8192) begin
                    m_mode  = 2;
                    m_valid = 1'b0;
                    m_inst  = 32'h0;
                end else begin
                    m_inst  = mem[m_pc / 4];
                    m_valid = 1'b1;
                    m_ipc   = m_pc;
                    m_ipc4  = m_pc + 4;
                    m_pc    = m_pc + 4;
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".if_valid"}, 32'(if_valid), 32'(m_valid));
        chk({where, ".if_inst"}, if_inst, m_inst);
        chk({where, ".if_pc"}, if_pc, m_ipc);
        chk({where, ".if_pc_plus4"}, if_pc_plus4, m_ipc4);
        chk({where, ".fault"}, 32'(fault), 32'(m_mode == 2));
        chk({where, ".imem_addr"}, 32'(imem_addr), (m_pc / 4) % 2048);
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    task automatic drive(input logic s, input logic rv,
                         input logic [31:0] rpc);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Asynchronous reset pulse in the middle of a clock phase.
    task automatic async_reset(input string where);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(where);
        #1;
        reset = 1'b0;
    endtask

    int halt_cnt;
    int r;
    logic [31:0] rpc;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[16] = 32'hAAAA_0001;
        drive(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Boot bubble, then first fetched word.
        cycle("boot");
        chk("boot.addr16", 32'(imem_addr), 32'd16);
        chk("boot.valid0", 32'(if_valid), 32'd0);
        cycle("first");
        chk("first.inst", if_inst, 32'hAAAA_0001);
        chk("first.pc", if_pc, 32'h40);
        chk("first.pc4", if_pc_plus4, 32'h44);

        // Straight-line run.
        for (int i = 1; i < 4; i++) begin
            cycle("run");
            chk("run.seq", if_pc, 32'h40 + 32'(4 * i));
        end

        // Stall at if_pc 0x44.
        drive(1'b0, 1'b1, 32'h44);
        cycle("to44");
        drive(1'b0, 1'b0, 32'h0);
        cycle("at44");
        drive(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.pc", if_pc, 32'h44);
            chk("stall.addr", 32'(imem_addr), 32'd18);
        end
        drive(1'b0, 1'b0, 32'h0);
        cycle("unstall");
        chk("unstall.pc", if_pc, 32'h48);

        // Redirect while stalled.
        drive(1'b1, 1'b1, 32'h100);
        cycle("redir_stall");
        chk("redir.valid0", 32'(if_valid), 32'd0);
        chk("redir.addr64", 32'(imem_addr), 32'd64);
        drive(1'b1, 1'b0, 32'h0);
        cycle("redir_hold");
        chk("redir_hold.valid0", 32'(if_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        cycle("redir_go");
        chk("redir_go.pc", if_pc, 32'h100);

        // Misaligned redirect faults; later redirects are ignored.
        drive(1'b0, 1'b1, 32'h102);
        cycle("misalign");
        chk("misalign.fault", 32'(fault), 32'd1);
        chk("misalign.valid0", 32'(if_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h200);
        cycle("halt_ign1");
        drive(1'b1, 1'b0, 32'h0);
        cycle("halt_ign2");
        chk("halt.fault", 32'(fault), 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        async_reset("reset2");
        chk("reset2.fault0", 32'(fault), 32'd0);

        // Run off the end of instruction memory.
        cycle("boot2");
        drive(1'b0, 1'b1, 32'h1FFC);
        cycle("to_end");
        drive(1'b0, 1'b0, 32'h0);
        cycle("last");
        chk("last.pc", if_pc, 32'h1FFC);
        chk("last.valid", 32'(if_valid), 32'd1);
        cycle("oob");
        chk("oob.fault", 32'(fault), 32'd1);
        chk("oob.valid0", 32'(if_valid), 32'd0);
        async_reset("reset3");

        // Randomized traffic.
        halt_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) rpc = 32'h1FF0 + 32'($urandom_range(0, 3) * 4);
            else if (r < 12) rpc = 32'($urandom_range(0, 8191)) | 32'h1;
            else if (r < 14) rpc = 32'hFFFF_FFF8;
            else rpc = 32'($urandom_range(0, 2047)) << 2;
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, rpc);
            cycle("rand");
            if (m_mode == 2) halt_cnt++;
            if (halt_cnt > 3 || $urandom_range(0, 99) == 0) begin
                halt_cnt = 0;
                async_reset("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
